// File: rtl/bitblt_udiv_16ns_8ns_seq.sv
// Sequential unsigned restoring divider (quotient bit per clock) with an
// ap_start/ap_ready/ap_done/ap_idle handshake for the bitblt control FSM.
module bitblt_udiv_16ns_8ns_seq #(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 8
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      ap_start,
  output logic                      ap_ready,
  output logic                      ap_idle,
  output logic                      ap_done,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);

  localparam int                CNT_W    = $clog2(DIVIDEND_WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DIVIDEND_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;
  logic   accept, last_step;

  logic [DIVIDEND_WIDTH-1:0] dvd_sr;
  logic [DIVISOR_WIDTH-1:0]  dsr_r;
  logic [DIVISOR_WIDTH:0]    prem;
  logic [CNT_W-1:0]          cnt;

  logic [DIVISOR_WIDTH:0]    shifted;
  logic [DIVISOR_WIDTH+1:0]  diff;
  logic                      q_bit;
  logic [DIVISOR_WIDTH:0]    prem_nxt;
  logic [DIVIDEND_WIDTH-1:0] dvd_nxt;

  // One restoring step. A set prem MSB means the true shifted value exceeds
  // any divisor, so the subtraction always succeeds in that case.
  always_comb begin
    shifted  = {prem[DIVISOR_WIDTH-1:0], dvd_sr[DIVIDEND_WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, dsr_r};
    q_bit    = prem[DIVISOR_WIDTH] | ~diff[DIVISOR_WIDTH+1];
    prem_nxt = q_bit ? diff[DIVISOR_WIDTH:0] : shifted;
    dvd_nxt  = {dvd_sr[DIVIDEND_WIDTH-2:0], q_bit};
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    ap_ready  = 1'b0;
    ap_idle   = 1'b0;
    ap_done   = 1'b0;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          ap_ready  = 1'b1;
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_ONE) begin
          last_step = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        ap_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dvd_sr      <= '0;
      dsr_r       <= '0;
      prem        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvd_sr <= dividend;
      dsr_r  <= divisor;
      prem   <= '0;
      cnt    <= CNT_LOAD;
    end else if (state == RUN) begin
      dvd_sr <= dvd_nxt;
      prem   <= prem_nxt;
      cnt    <= cnt - CNT_ONE;
      if (last_step) begin
        // Zero divisor runs the full latency, then reports a saturated quotient.
        if (dsr_r == '0) begin
          quotient    <= '1;
          remainder   <= '0;
          div_by_zero <= 1'b1;
        end else begin
          quotient    <= dvd_nxt;
          remainder   <= prem_nxt[DIVISOR_WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bitblt_udiv_16ns_8ns_seq.sv
// Directed and random bench for the sequential divider: arithmetic model with a
// request queue, per-cycle compare process, and hand-computed literal checks.
module tb_bitblt_udiv_16ns_8ns_seq;

  localparam int LAT = 17;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic        ap_ready, ap_idle, ap_done;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  bitblt_udiv_16ns_8ns_seq dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out or unexpected event (t=%0t)", name, $time);
  endtask

  // Reference model: plain integer division, saturated on a zero divisor.
  function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [7:0] b);
    return (b == 0) ? 16'hFFFF : a / b;
  endfunction

  function automatic logic [7:0] ref_r(input logic [15:0] a, input logic [7:0] b);
    return (b == 0) ? 8'd0 : 8'(a % b);
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    int          acc;
  } req_t;

  req_t        pend[$];
  logic        last_done = 1'b0;
  logic [15:0] last_q = '0;
  logic [7:0]  last_r = '0;
  logic        last_z = 1'b0;

  // Compare process: model every accepted request and check each completion,
  // its latency, the pulse width, and that results hold between completions.
  always @(negedge ap_clk) begin : cmp
    req_t r;
    if (!ap_rst_n) begin
      pend.delete();
      last_done <= 1'b0;
      last_q    <= '0;
      last_r    <= '0;
      last_z    <= 1'b0;
    end else begin
      if (ap_ready) begin
        check("ready_only_idle_start", {30'd0, ap_idle, ap_start}, 32'd3);
        pend.push_back('{dividend, divisor, cyc});
      end
      if (ap_done) begin
        check("done_one_cycle", {31'd0, last_done}, 32'd0);
        check("done_not_idle", {31'd0, ap_idle}, 32'd0);
        if (pend.size() == 0) begin
          flag_fail("spurious_done");
        end else begin
          r = pend.pop_front();
          check("model_quotient", {16'd0, quotient}, {16'd0, ref_q(r.a, r.b)});
          check("model_remainder", {24'd0, remainder}, {24'd0, ref_r(r.a, r.b)});
          check("model_dbz", {31'd0, div_by_zero}, {31'd0, (r.b == 0)});
          check("model_latency", cyc - r.acc, LAT);
          last_q <= ref_q(r.a, r.b);
          last_r <= ref_r(r.a, r.b);
          last_z <= (r.b == 0);
        end
      end else begin
        check("hold_results", {7'd0, quotient, remainder, div_by_zero},
              {7'd0, last_q, last_r, last_z});
      end
      last_done <= ap_done;
    end
  end

  task automatic wait_ready(output int acc);
    bit seen = 0;
    acc = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge ap_clk);
      if (ap_ready) begin
        seen = 1;
        acc  = cyc;
      end
    end
    if (!seen) flag_fail("wait_ready");
  endtask

  task automatic wait_done(input int acc, input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge ap_clk);
      if (ap_done) seen = 1;
    end
    if (!seen) flag_fail({name, "_wait_done"});
    else       check({name, "_latency"}, cyc - acc, LAT);
  endtask

  // Issue one request, scramble operands right after acceptance, wait for done.
  task automatic do_div(input logic [15:0] a, input logic [7:0] b, input string name);
    int acc;
    @(posedge ap_clk); #1;
    dividend = a;
    divisor  = b;
    ap_start = 1'b1;
    wait_ready(acc);
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    wait_done(acc, name);
  endtask

  task automatic div_expect(input logic [15:0] a, input logic [7:0] b,
                            input logic [15:0] eq, input logic [7:0] er,
                            input logic ez, input string name);
    do_div(a, b, name);
    check({name, "_q"}, {16'd0, quotient}, {16'd0, eq});
    check({name, "_r"}, {24'd0, remainder}, {24'd0, er});
    check({name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
  endtask

  initial begin
    int acc1, acc2;
    bit got_done;

    // Reset state
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_idle", {31'd0, ap_idle}, 32'd1);
    check("rst_ready", {31'd0, ap_ready}, 32'd0);
    check("rst_done", {31'd0, ap_done}, 32'd0);
    check("rst_outs", {7'd0, quotient, remainder, div_by_zero}, 32'd0);
    ap_rst_n = 1'b1;

    // Hand-computed directed vectors
    div_expect(16'd1000,  8'd7,   16'd142,   8'd6,  1'b0, "basic");
    div_expect(16'd65535, 8'd255, 16'd257,   8'd0,  1'b0, "max_by_max");
    div_expect(16'd65535, 8'd1,   16'd65535, 8'd0,  1'b0, "max_by_one");
    div_expect(16'd5,     8'd9,   16'd0,     8'd5,  1'b0, "small_by_big");
    div_expect(16'd0,     8'd3,   16'd0,     8'd0,  1'b0, "zero_dividend");
    div_expect(16'd1234,  8'd0,   16'd65535, 8'd0,  1'b1, "div_zero");
    div_expect(16'd20,    8'd4,   16'd5,     8'd0,  1'b0, "after_div_zero");

    // Back-to-back with ap_start held high; operands change during RUN
    @(posedge ap_clk); #1;
    dividend = 16'd100;
    divisor  = 8'd10;
    ap_start = 1'b1;
    wait_ready(acc1);
    @(posedge ap_clk); #1;
    dividend = 16'd255;
    divisor  = 8'd16;
    wait_done(acc1, "b2b_first");
    check("b2b_first_q", {16'd0, quotient}, 32'd10);
    check("b2b_first_r", {24'd0, remainder}, 32'd0);
    wait_ready(acc2);
    check("b2b_spacing", acc2 - acc1, 18);
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    dividend = 16'd7;
    divisor  = 8'd1;
    wait_done(acc2, "b2b_second");
    check("b2b_second_q", {16'd0, quotient}, 32'd15);
    check("b2b_second_r", {24'd0, remainder}, 32'd15);

    // Reset during RUN cycle 8 aborts the division
    @(posedge ap_clk); #1;
    dividend = 16'd40000;
    divisor  = 8'd3;
    ap_start = 1'b1;
    wait_ready(acc1);
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    repeat (8) @(posedge ap_clk);
    #1 ap_rst_n = 1'b0;
    got_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      if (ap_done) got_done = 1;
    end
    check("abort_no_done", {31'd0, got_done}, 32'd0);
    check("abort_idle", {31'd0, ap_idle}, 32'd1);
    check("abort_outs", {7'd0, quotient, remainder, div_by_zero}, 32'd0);
    ap_rst_n = 1'b1;
    div_expect(16'd40000, 8'd3, 16'd13333, 8'd1, 1'b0, "after_abort");

    // Random operands, checked by the compare process against the model
    for (int i = 0; i < 1500; i++) begin
      do_div(16'($urandom), (i % 50 == 7) ? 8'd0 : 8'($urandom), "rand");
    end

    repeat (3) @(negedge ap_clk);
    check("queue_drained", pend.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
